// File: rtl/serializer_5bit_fsm.sv
// Parallel-in, serial-out framer feeding the 5-bit left shift register.
// Handshaked word load, MSB- or LSB-first emission, frame flags and a programmable idle gap.
module serializer_5bit_fsm #(
  parameter int unsigned WIDTH     = 5,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned IDLE_GAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_first,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam int unsigned      GAP_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (IDLE_GAP == 0) ? GAP_W'(0) : GAP_W'(IDLE_GAP - 1);
  localparam bit               NO_GAP   = (IDLE_GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             accept;

  // State register; reset discards any partially sent frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Output decode from registers, then next-state logic
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;

    sout_valid  = (state_q == ST_SHIFT);
    data_ready  = (state_q == ST_IDLE) | (sout_valid & (cnt_q == '0) & NO_GAP);
    sout        = sout_valid & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    frame_first = sout_valid & (cnt_q == CNT_LAST);
    frame_done  = sout_valid & (cnt_q == '0);
    busy        = (state_q != ST_IDLE);
    accept      = data_valid & data_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sreg_d  = data_in;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
          cnt_d  = CNT_W'(cnt_q - 1'b1);
        end else if (accept) begin
          // Back-to-back reload: next frame's first bit follows with no bubble
          sreg_d = data_in;
          cnt_d  = CNT_LAST;
        end else if (NO_GAP) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          gcnt_d  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = GAP_W'(gcnt_q - 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/serializer_5bit_fsm.md
Name: serializer_5bit_fsm

Overview:
- Upstream stage of the 5-bit left shift register; sout drives that register's serial input.
- Accepts a parallel word over a valid/ready handshake and emits it one bit per clock, either MSB-first or LSB-first.
- Flags the first and last bit of each frame.
- Enforces a programmable idle gap between frames.

Parameters:
- WIDTH, 5, word width in bits (≥2).
- MSB_FIRST, 1, 1 = transmit data_in[WIDTH-1] first; 0 = transmit data_in[0] first.
- IDLE_GAP, 0, number of idle cycles forced after each frame (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on accept.
- data_valid  input  1  upstream has a word.
- data_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit; 0 when sout_valid=0.
- sout_valid  output  1  sout carries a frame bit.
- frame_first  output  1  high on the first bit of a frame.
- frame_done  output  1  high on the last bit of a frame.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Registers: state {IDLE, SHIFT, GAP}, sreg[WIDTH], bit counter cnt (bits remaining minus 1), gap counter gcnt.
- Reset (async, any time, including mid-frame):
  - state=IDLE, sreg=0, cnt=0, gcnt=0.
  - Outputs: data_ready=1, all other outputs 0.
  - A partially sent frame is discarded, never resumed.
- accept = data_valid & data_ready, sampled on the rising edge.
- Output decode (combinational from registers only):
  - data_ready = (state==IDLE) | (state==SHIFT & cnt==0 & IDLE_GAP==0).
  - sout_valid = (state==SHIFT).
  - sout = sout_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 0.
  - frame_first = SHIFT & cnt==WIDTH-1.
  - frame_done = SHIFT & cnt==0.
  - busy = state!=IDLE.
- IDLE:
  - On accept: sreg<=data_in, cnt<=WIDTH-1, state<=SHIFT.
  - First bit appears in the cycle after the accept edge, so latency is 1 clock.
- SHIFT, each edge:
  - If cnt!=0: sreg shifts toward the output end (left if MSB_FIRST, right otherwise), zero-fill; cnt<=cnt-1.
  - If cnt==0 and accept (only possible when IDLE_GAP==0): reload as in IDLE and stay in SHIFT, giving back-to-back frames with no bubble.
  - If cnt==0, no accept, IDLE_GAP==0: state<=IDLE.
  - If cnt==0, IDLE_GAP>0: state<=GAP, gcnt<=IDLE_GAP-1.
- GAP:
  - data_ready=0; data_valid is ignored.
  - gcnt decrements each edge; at gcnt==0, state<=IDLE.
  - Exactly IDLE_GAP cycles with busy=1 and sout_valid=0.
- Timing totals:
  - A frame occupies exactly WIDTH consecutive sout_valid cycles.
  - frame_first and frame_done are each asserted exactly once per frame, both single-cycle.
- Input rules:
  - data_valid while data_ready=0 is ignored; no queueing.
  - data_in changes outside the accept edge have no effect.
  - Upstream may hold data_valid high; one word is taken per accept.

Test Plan:
- Reset, then MSB_FIRST=1: data_in=5'b10110, data_valid pulsed 1 cycle → sout=1,0,1,1,0 on the next 5 cycles; sout_valid high for exactly 5 cycles; frame_first on bit 1; frame_done on bit 5; then data_ready=1, busy=0.
- Back-to-back, IDLE_GAP=0, data_valid held with 5'b10110 then 5'b01001 → 10 contiguous sout_valid cycles with sout=1011001001; data_ready high on cycles 5 and 10; two frame_done pulses.
- IDLE_GAP=2, two words queued → after frame_done: 2 cycles with busy=1, data_ready=0, sout_valid=0; second frame starts on the 4th cycle after frame_done.
- MSB_FIRST=0, data_in=5'b10110 → sout=0,1,1,0,1.
- reset asserted asynchronously between edges after bit 2 of 5'b11111 → sout, sout_valid, busy drop to 0 immediately and data_ready=1; after release, a new word 5'b00001 transmits cleanly as 0,0,0,0,1.
- data_valid pulsed with 5'b00000 while mid-frame (data_ready=0) → word ignored; only the original frame is emitted.
